// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
// Optional timeout support is enabled with MEM_ARBITER_TIMEOUT_EN.
package mem_arbiter_pkg;

  localparam int unsigned DefWordW     = 32;
  localparam int unsigned DefStarveMax = 3;
  localparam int unsigned DefTimeout   = 64;

  typedef logic [DefWordW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Width of a counter that must reach max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/RAM bus bundle for mem_arbiter; slave = arbiter side, master = environment side.
// The err signal exists only when MEM_ARBITER_TIMEOUT_EN is defined.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW
) ();

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              ram_ready;
  logic [WORD_W-1:0] ram_load;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic              busy;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic              err;
`endif

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy
`ifdef MEM_ARBITER_TIMEOUT_EN
    , output err
`endif
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy
`ifdef MEM_ARBITER_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access, data first with a
// starvation guard for fetch. Define MEM_ARBITER_TIMEOUT_EN to abort stalled grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W     = DefWordW,
  parameter int unsigned STARVE_MAX = DefStarveMax
`ifdef MEM_ARBITER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = DefTimeout
`endif
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned          StarveW    = cnt_width(STARVE_MAX);
  localparam logic [StarveW-1:0]   StarveMaxC = StarveW'(STARVE_MAX);

  arb_state_t        r_state, w_state_d;
  logic [StarveW-1:0] r_starve, w_starve_d;
  logic              r_ihit, w_ihit_d;
  logic              r_dhit, w_dhit_d;
  logic [WORD_W-1:0] r_iload, w_iload_d;
  logic [WORD_W-1:0] r_dload, w_dload_d;
  logic              r_ramREN, w_ramREN_d;
  logic              r_ramWEN, w_ramWEN_d;
  logic [WORD_W-1:0] r_ramaddr, w_ramaddr_d;
  logic [WORD_W-1:0] r_ramstore, w_ramstore_d;
  logic              r_busy, w_busy_d;
  logic              w_dreq;
  logic              w_force_i;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned      TmoW    = cnt_width(TIMEOUT);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

  logic [TmoW-1:0] r_tmo, w_tmo_d;
  logic            r_err, w_err_d;
`endif

  assign w_dreq    = bus.dREN | bus.dWEN;
  // Fetch has waited through STARVE_MAX data grants: it goes next.
  assign w_force_i = bus.iREN && (r_starve == StarveMaxC);

  always_comb begin
    w_state_d    = r_state;
    w_starve_d   = r_starve;
    w_ihit_d     = 1'b0;
    w_dhit_d     = 1'b0;
    w_iload_d    = r_iload;
    w_dload_d    = r_dload;
    w_ramREN_d   = r_ramREN;
    w_ramWEN_d   = r_ramWEN;
    w_ramaddr_d  = r_ramaddr;
    w_ramstore_d = r_ramstore;
`ifdef MEM_ARBITER_TIMEOUT_EN
    w_tmo_d      = r_tmo;
    w_err_d      = r_err;
`endif
    unique case (r_state)
      IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
        w_tmo_d = '0;
`endif
        if (w_dreq && !w_force_i) begin
          w_state_d    = GRANT_D;
          w_ramaddr_d  = bus.daddr;
          w_ramstore_d = bus.dstore;
          w_ramWEN_d   = bus.dWEN;
          w_ramREN_d   = bus.dREN & ~bus.dWEN;
          if (bus.iREN && (r_starve != StarveMaxC)) begin
            w_starve_d = r_starve + 1'b1;
          end
        end else if (bus.iREN) begin
          w_state_d   = GRANT_I;
          w_ramaddr_d = bus.iaddr;
          w_ramREN_d  = 1'b1;
          w_ramWEN_d  = 1'b0;
          w_starve_d  = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.ram_ready) begin
          w_state_d  = IDLE;
          w_ramREN_d = 1'b0;
          w_ramWEN_d = 1'b0;
          if (r_state == GRANT_I) begin
            w_ihit_d  = 1'b1;
            w_iload_d = bus.ram_load;
          end else begin
            w_dhit_d = 1'b1;
            if (r_ramREN) begin
              w_dload_d = bus.ram_load;
            end
          end
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (r_tmo == TmoLast) begin
          // Abort silently; the still-pending requester is re-arbitrated from IDLE.
          w_state_d  = IDLE;
          w_ramREN_d = 1'b0;
          w_ramWEN_d = 1'b0;
          w_err_d    = 1'b1;
        end else begin
          w_tmo_d = r_tmo + 1'b1;
        end
`endif
      end
      default: w_state_d = IDLE;
    endcase
    w_busy_d = (w_state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_busy     <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      r_tmo      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_starve   <= w_starve_d;
      r_ihit     <= w_ihit_d;
      r_dhit     <= w_dhit_d;
      r_iload    <= w_iload_d;
      r_dload    <= w_dload_d;
      r_ramREN   <= w_ramREN_d;
      r_ramWEN   <= w_ramWEN_d;
      r_ramaddr  <= w_ramaddr_d;
      r_ramstore <= w_ramstore_d;
      r_busy     <= w_busy_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
      r_tmo      <= w_tmo_d;
      r_err      <= w_err_d;
`endif
    end
  end

  assign bus.ihit     = r_ihit;
  assign bus.dhit     = r_dhit;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;
  assign bus.busy     = r_busy;
`ifdef MEM_ARBITER_TIMEOUT_EN
  assign bus.err      = r_err;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, random traffic against a
// transaction-level model, and hand sequences for starvation, reset and timeout.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned STARVE = 3;
  localparam int unsigned TMO    = 8;
  localparam int          NRAND  = 3000;

  logic CLK = 1'b0;
  logic nRST;

  mem_arbiter_if #(.WORD_W(W)) bus ();

`ifdef MEM_ARBITER_TIMEOUT_EN
  mem_arbiter #(.WORD_W(W), .STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );
`else
  mem_arbiter #(.WORD_W(W), .STARVE_MAX(STARVE)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );
`endif

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        rdy;
    logic [31:0] load;
    logic        e_ihit;
    logic        e_dhit;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_busy;
  } vec_t;

  vec_t vecs[12];

  // Transaction-level reference: who owns the RAM, what was latched, starvation tally.
  int          m_owner;  // 0 none, 1 fetch, 2 data
  int          m_starve;
  int          m_wait;
  logic        m_ihit, m_dhit, m_ren, m_wen, m_busy, m_err;
  logic [31:0] m_iload, m_dload, m_addr, m_store;

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_wait = 0;
    m_ihit = 1'b0; m_dhit = 1'b0; m_ren = 1'b0; m_wen = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    m_iload = '0; m_dload = '0; m_addr = '0; m_store = '0;
  endtask

  task automatic model_step();
    m_ihit = 1'b0;
    m_dhit = 1'b0;
    if (m_owner == 0) begin
      m_wait = 0;
      if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_starve == STARVE)) begin
        m_owner = 2;
        m_addr  = bus.daddr;
        m_store = bus.dstore;
        m_wen   = bus.dWEN;
        m_ren   = bus.dREN && !bus.dWEN;
        if (bus.iREN) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
      end else if (bus.iREN) begin
        m_owner  = 1;
        m_addr   = bus.iaddr;
        m_ren    = 1'b1;
        m_wen    = 1'b0;
        m_starve = 0;
      end
    end else if (bus.ram_ready) begin
      if (m_owner == 1) begin
        m_ihit  = 1'b1;
        m_iload = bus.ram_load;
      end else begin
        m_dhit = 1'b1;
        if (m_ren) m_dload = bus.ram_load;
      end
      m_ren   = 1'b0;
      m_wen   = 1'b0;
      m_owner = 0;
    end else begin
      m_wait++;
`ifdef MEM_ARBITER_TIMEOUT_EN
      if (m_wait == TMO) begin
        m_ren   = 1'b0;
        m_wen   = 1'b0;
        m_owner = 0;
        m_err   = 1'b1;
      end
`endif
    end
    m_busy = (m_owner != 0);
  endtask

  task automatic drive_zero();
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 1'b0; bus.ram_load = '0;
  endtask

  task automatic do_reset();
    drive_zero();
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  initial begin
    logic        i_pend, d_pend;
    int          got[5];
    int          exp_order[5];
    int          ngrant, nd, rencnt;
    logic        prev_busy, saw_ihit;

    nRST = 1'b0;
    drive_zero();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk1("rst_ihit", bus.ihit, 1'b0);
    chk1("rst_dhit", bus.dhit, 1'b0);
    chk1("rst_ramREN", bus.ramREN, 1'b0);
    chk1("rst_ramWEN", bus.ramWEN, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chkw("rst_ramaddr", bus.ramaddr, 32'h0);
    chkw("rst_ramstore", bus.ramstore, 32'h0);
    chkw("rst_iload", bus.iload, 32'h0);
    chkw("rst_dload", bus.dload, 32'h0);
`ifdef MEM_ARBITER_TIMEOUT_EN
    chk1("rst_err", bus.err, 1'b0);
`endif
    nRST = 1'b1;

    // ---- directed vector table ----
    vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2008_0005,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2008_0005, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2008_0005, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678,
                 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h2008_0005, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hAAAA_0001,
                 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h2008_0005, 32'hAAAA_0001, 1'b0};
    vecs[9]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h2008_0005, 32'hAAAA_0001, 1'b1};
    vecs[10] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBBBB_0002,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001, 1'b0};

    for (int i = 0; i < 12; i++) begin
      bus.iREN = vecs[i].iren;   bus.iaddr = vecs[i].iaddr;
      bus.dREN = vecs[i].dren;   bus.dWEN = vecs[i].dwen;
      bus.daddr = vecs[i].daddr; bus.dstore = vecs[i].dstore;
      bus.ram_ready = vecs[i].rdy; bus.ram_load = vecs[i].load;
      @(posedge CLK);
      @(negedge CLK);
      chk1($sformatf("vec%0d_ihit", i), bus.ihit, vecs[i].e_ihit);
      chk1($sformatf("vec%0d_dhit", i), bus.dhit, vecs[i].e_dhit);
      chk1($sformatf("vec%0d_ramREN", i), bus.ramREN, vecs[i].e_ren);
      chk1($sformatf("vec%0d_ramWEN", i), bus.ramWEN, vecs[i].e_wen);
      chkw($sformatf("vec%0d_ramaddr", i), bus.ramaddr, vecs[i].e_addr);
      chkw($sformatf("vec%0d_ramstore", i), bus.ramstore, vecs[i].e_store);
      chkw($sformatf("vec%0d_iload", i), bus.iload, vecs[i].e_iload);
      chkw($sformatf("vec%0d_dload", i), bus.dload, vecs[i].e_dload);
      chk1($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
    end

    // ---- random traffic against the reference model ----
    do_reset();
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      model_step();
      @(posedge CLK);
      @(negedge CLK);
      chk1("rnd_ihit", bus.ihit, m_ihit);
      chk1("rnd_dhit", bus.dhit, m_dhit);
      chk1("rnd_ramREN", bus.ramREN, m_ren);
      chk1("rnd_ramWEN", bus.ramWEN, m_wen);
      chkw("rnd_ramaddr", bus.ramaddr, m_addr);
      chkw("rnd_ramstore", bus.ramstore, m_store);
      chkw("rnd_iload", bus.iload, m_iload);
      chkw("rnd_dload", bus.dload, m_dload);
      chk1("rnd_busy", bus.busy, m_busy);
      chk1("rnd_no_coincide", bus.ihit & bus.dhit, 1'b0);
`ifdef MEM_ARBITER_TIMEOUT_EN
      chk1("rnd_err", bus.err, m_err);
`endif
      if (m_ihit) i_pend = 1'b0;
      if (m_dhit) d_pend = 1'b0;
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend    = 1'b1;
        bus.iaddr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        int kind;
        kind       = int'($urandom_range(0, 2));
        d_pend     = 1'b1;
        bus.dREN   = (kind != 1);
        bus.dWEN   = (kind != 0);
        bus.daddr  = $urandom;
        bus.dstore = $urandom;
      end
      bus.iREN = i_pend;
      if (!d_pend) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
      bus.ram_ready = ($urandom_range(0, 1) == 0);
      bus.ram_load  = $urandom;
    end

    // ---- starvation: fetch held, data re-requesting, RAM always ready ----
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h55;
    bus.ram_ready = 1'b1;
    exp_order = '{1, 1, 1, 0, 1};
    got = '{-1, -1, -1, -1, -1};
    ngrant = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 60 && ngrant < 5; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk1("stv_no_coincide", bus.ihit & bus.dhit, 1'b0);
      if (bus.busy && !prev_busy) begin
        got[ngrant] = bus.ramWEN ? 1 : 0;
        ngrant++;
      end
      if (bus.ihit) bus.iREN = 1'b0;
      prev_busy = bus.busy;
    end
    for (int k = 0; k < 5; k++) begin
      chkw($sformatf("starve_grant%0d", k), 32'(got[k]), 32'(exp_order[k]));
    end

    // ---- reset mid-GRANT_D with the starvation tally at its maximum ----
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h300;
    bus.dWEN = 1'b1; bus.daddr = 32'h400;
    bus.ram_ready = 1'b1;
    nd = 0;
    saw_ihit = 1'b0;
    for (int c = 0; c < 30 && nd < 3; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.dhit) nd++;
      if (bus.ihit) saw_ihit = 1'b1;
    end
    chkw("rst_seq_dhits", 32'(nd), 32'd3);
    chk1("rst_seq_no_ihit", saw_ihit, 1'b0);
    bus.iREN = 1'b0; bus.dWEN = 1'b0; bus.dREN = 1'b1;
    bus.daddr = 32'h500; bus.ram_ready = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    chk1("rst_seq_busy_pre", bus.busy, 1'b1);
    chkw("rst_seq_addr_pre", bus.ramaddr, 32'h500);
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk1("rst_seq_ramREN", bus.ramREN, 1'b0);
    chk1("rst_seq_ramWEN", bus.ramWEN, 1'b0);
    chk1("rst_seq_busy", bus.busy, 1'b0);
    chk1("rst_seq_dhit", bus.dhit, 1'b0);
    nRST = 1'b1;
    bus.iREN = 1'b1; bus.iaddr = 32'h600;
    bus.dREN = 1'b1; bus.daddr = 32'h700;
    @(posedge CLK);
    @(negedge CLK);
    // A cleared tally lets data win; a surviving tally of 3 would force fetch.
    chkw("rst_seq_starve_cleared", bus.ramaddr, 32'h700);
    chk1("rst_seq_regrant_ren", bus.ramREN, 1'b1);

`ifdef MEM_ARBITER_TIMEOUT_EN
    // ---- timeout: fetch grant with RAM never ready ----
    do_reset();
    bus.iREN = 1'b1; bus.iaddr = 32'h900; bus.ram_ready = 1'b0;
    rencnt = 0;
    saw_ihit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.ihit) saw_ihit = 1'b1;
      if (bus.ramREN) rencnt++;
      else if (rencnt > 0) break;
    end
    chkw("tmo_grant_cycles", 32'(rencnt), 32'(TMO));
    chk1("tmo_err", bus.err, 1'b1);
    chk1("tmo_no_ihit", saw_ihit, 1'b0);
    chk1("tmo_idle", bus.busy, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    chk1("tmo_regrant", bus.ramREN, 1'b1);
    chk1("tmo_err_sticky", bus.err, 1'b1);
`else
    rencnt = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
